ram_4x4_wr: RTL

- Writable 4-entry x 4-bit synchronous memory. It is the write-side counterpart of the team's combinational 2-bit-address / 4-bit-data ROM.
- Clears itself after reset, then accepts writes through a valid/ready handshake and serves registered reads.
- A sticky lock input freezes the contents, so the block then behaves as a ROM. Writers can load the table once and readers see ROM-like behaviour.

---
 rtl/ram_4x4_wr.sv | 89 ++++++++
 1 files changed

// File: rtl/ram_4x4_wr.sv
// Writable DEPTH x DATA_W memory: clears itself after reset, takes writes on a valid/ready
// handshake, serves 1-cycle registered reads, and can be locked read-only until reset.
module ram_4x4_wr #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              lock,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              locked,
  output logic              wr_err
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {INIT, RUN, LOCKED} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            rd_data_q;
  logic                         rd_valid_q, wr_err_q;

  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_waddr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         rd_fire;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = '0;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == ADDR_W'(DEPTH-1)) state_d = RUN;
      end
      RUN: begin
        // a write in the same cycle as lock still lands
        mem_we = wr_valid;
        if (lock) state_d = LOCKED;
      end
      default: ;
    endcase
  end

  assign rd_fire = rd_en && (state_q != INIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      rd_valid_q <= rd_fire;
      wr_err_q   <= (state_q == LOCKED) && wr_valid;
      if (rd_fire) rd_data_q <= mem_q[rd_addr];
    end
  end

  // storage is not reset; INIT clears it, and reads use the pre-edge value (read-first)
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign wr_ready = (state_q != INIT);
  assign busy     = (state_q == INIT);
  assign locked   = (state_q == LOCKED);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
endmodule
